// File: rtl/t_ff_counter.sv
// WIDTH-bit T flip-flop bank: per-bit toggle register (mode 0) or synchronous T-FF cascade counter (mode 1).
// Optional macro TFF_UPDOWN_EN adds the dir port for down-counting; q updates one clk after its inputs.
module t_ff_counter #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [WIDTH-1:0] t,
  input  logic             en,
`ifdef TFF_UPDOWN_EN
  input  logic             dir,
`endif
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc
);

  logic             down;
  logic [WIDTH-1:0] cnt_tog;
  logic [WIDTH-1:0] tog;
  logic             at_term;

`ifdef TFF_UPDOWN_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  // Counter toggles ripple through the cascade: a bit flips when every lower bit
  // is 1 (up) or 0 (down), which carries/borrows without an adder.
  always_comb begin
    cnt_tog    = '0;
    cnt_tog[0] = en;
    for (int i = 1; i < WIDTH; i++) begin
      cnt_tog[i] = cnt_tog[i-1] & (down ? ~q[i-1] : q[i-1]);
    end
  end

  assign tog = mode ? cnt_tog : t;

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q ^ tog;
    end
  end

  always_comb begin
    at_term = &q;
    if (down) begin
      at_term = ~|q;
    end
  end

  assign q_n = ~q;
  assign tc  = mode & en & at_term;

endmodule

// File: tb/tb_t_ff_counter.sv
// Self-checking bench for t_ff_counter (WIDTH=4, RESET_VAL=0); arithmetic reference model.
module tb_t_ff_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, mode, en, dir, load;
  logic [W-1:0] t, d, q, q_n;
  logic         tc;
  logic [W-1:0] exp_q;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  t_ff_counter #(.WIDTH(W), .RESET_VAL(4'h0)) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .t(t),
    .en(en),
`ifdef TFF_UPDOWN_EN
    .dir(dir),
`endif
    .load(load),
    .d(d),
    .q(q),
    .q_n(q_n),
    .tc(tc)
  );

  function automatic logic use_down();
`ifdef TFF_UPDOWN_EN
    return dir;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: priority reset > load > mode, counter as plain +/-1 modulo 16.
  function automatic logic [W-1:0] model_next();
    int v;
    if (!reset) return 4'h0;
    if (load) return d;
    if (!mode) return exp_q ^ t;
    if (!en) return exp_q;
    v = use_down() ? (int'(exp_q) + 15) % 16 : (int'(exp_q) + 1) % 16;
    return W'(v);
  endfunction

  function automatic logic model_tc();
    if (!(mode && en)) return 1'b0;
    return use_down() ? (exp_q == 4'h0) : (exp_q == 4'hF);
  endfunction

  task automatic tick();
    exp_q = model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b1; load = 1'b0; mode = 1'b0; en = 1'b0; dir = 1'b0;
    t = '0; d = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0; load = 1'b1; d = 4'hA; mode = 1'b1; en = 1'b1; t = 4'hF;
    tick(); tick();
    n_checks++;
    if (q !== 4'h0) begin n_fail++; $display("FAIL reset_q got %h want 0", q); end
    n_checks++;
    if (q_n !== 4'hF) begin n_fail++; $display("FAIL reset_qn got %h want F", q_n); end
    n_checks++;
    if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc got %b want 0", tc); end
    reset = 1'b1; load = 1'b1; d = 4'h5; mode = 1'b0; en = 1'b0; t = '0;
    tick();
    load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (q !== 4'h5) begin n_fail++; $display("FAIL reset_midcycle got %h want 5", q); end
    tick();
    n_checks++;
    if (q !== 4'h0) begin n_fail++; $display("FAIL reset_next_edge got %h want 0", q); end
    reset = 1'b1;
  endtask

  task automatic test_toggle();
    logic [W-1:0] tv [3];
    logic [W-1:0] ev [3];
    tv = '{4'b0101, 4'b1111, 4'b0000};
    ev = '{4'b0101, 4'b1010, 4'b1010};
    idle();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t = tv[i];
      n_checks++;
      if (tc !== 1'b0) begin n_fail++; $display("FAIL toggle_tc[%0d] got %b want 0", i, tc); end
      tick();
      n_checks++;
      if (q !== ev[i]) begin n_fail++; $display("FAIL toggle_q[%0d] got %h want %h", i, q, ev[i]); end
    end
  endtask

  task automatic test_count_wrap();
    logic [W-1:0] qv [4];
    logic         tv [4];
    qv = '{4'hE, 4'hF, 4'h0, 4'h1};
    tv = '{1'b0, 1'b0, 1'b1, 1'b0};
    idle();
    mode = 1'b1; load = 1'b1; d = 4'hD;
    tick();
    n_checks++;
    if (q !== 4'hD) begin n_fail++; $display("FAIL count_load got %h want D", q); end
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tc !== tv[i]) begin n_fail++; $display("FAIL count_tc[%0d] got %b want %b", i, tc, tv[i]); end
      tick();
      n_checks++;
      if (q !== qv[i]) begin n_fail++; $display("FAIL count_q[%0d] got %h want %h", i, q, qv[i]); end
    end
    load = 1'b1; d = 4'hF;
    tick();
    load = 1'b0; en = 1'b0;
    #1;
    n_checks++;
    if (tc !== 1'b0) begin n_fail++; $display("FAIL hold_tc got %b want 0", tc); end
    tick();
    n_checks++;
    if (q !== 4'hF) begin n_fail++; $display("FAIL hold_q got %h want F", q); end
  endtask

  task automatic test_priority();
    idle();
    mode = 1'b1; load = 1'b1; d = 4'h3;
    tick();
    en = 1'b1; load = 1'b1; d = 4'h9;
    tick();
    n_checks++;
    if (q !== 4'h9) begin n_fail++; $display("FAIL prio_load got %h want 9", q); end
    en = 1'b0; d = 4'h3;
    tick();
    en = 1'b1; d = 4'h9; reset = 1'b0;
    tick();
    n_checks++;
    if (q !== 4'h0) begin n_fail++; $display("FAIL prio_reset got %h want 0", q); end
    reset = 1'b1; load = 1'b0;
  endtask

  task automatic test_mode_switch();
    idle();
    mode = 1'b1; load = 1'b1; d = 4'h5;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    n_checks++;
    if (q !== 4'h6) begin n_fail++; $display("FAIL switch_count got %h want 6", q); end
    mode = 1'b0; t = 4'b0001; en = 1'b0;
    tick();
    n_checks++;
    if (q !== 4'h7) begin n_fail++; $display("FAIL switch_toggle got %h want 7", q); end
    mode = 1'b1; en = 1'b1; t = 4'h0;
    tick();
    n_checks++;
    if (q !== 4'h8) begin n_fail++; $display("FAIL switch_back got %h want 8", q); end
  endtask

`ifdef TFF_UPDOWN_EN
  task automatic test_updown();
    logic [W-1:0] qv [4];
    logic         tv [4];
    qv = '{4'h1, 4'h0, 4'hF, 4'hE};
    tv = '{1'b0, 1'b0, 1'b1, 1'b0};
    idle();
    mode = 1'b1; load = 1'b1; d = 4'h2;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tc !== tv[i]) begin n_fail++; $display("FAIL down_tc[%0d] got %b want %b", i, tc, tv[i]); end
      tick();
      n_checks++;
      if (q !== qv[i]) begin n_fail++; $display("FAIL down_q[%0d] got %h want %h", i, q, qv[i]); end
    end
    dir = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 19) != 0);
      load  = ($urandom_range(0, 7) == 0);
      mode  = 1'($urandom);
      en    = ($urandom_range(0, 3) != 0);
      dir   = 1'($urandom);
      t     = W'($urandom);
      d     = W'($urandom);
      #1;
      n_checks++;
      if (q_n !== ~exp_q) begin n_fail++; $display("FAIL rand_qn[%0d] got %h want %h", i, q_n, ~exp_q); end
      n_checks++;
      if (tc !== model_tc()) begin n_fail++; $display("FAIL rand_tc[%0d] got %b want %b", i, tc, model_tc()); end
      tick();
      n_checks++;
      if (q !== exp_q) begin n_fail++; $display("FAIL rand_q[%0d] got %h want %h", i, q, exp_q); end
    end
  endtask

  initial begin
    idle();
    exp_q = 'x;
    test_reset();
    test_toggle();
    test_count_wrap();
    test_priority();
    test_mode_switch();
`ifdef TFF_UPDOWN_EN
    test_updown();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
